// File: rtl/tail_sequencer.sv
// tail_sequencer: dual-side thermometer turn/hazard lamp sequencer with dwell prescaler
module tail_sequencer #(
   parameter int N   = 3,
   parameter int DIV = 1,
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         left,
   input  logic         right,
   input  logic         hazard,
   output logic [N-1:0] lamps_l,
   output logic [N-1:0] lamps_r,
   output logic         busy
);
   localparam int PW = $clog2(N + 1);
   typedef enum logic [2:0] {S_IDLE, S_LEFT, S_RIGHT, S_HAZ_ON, S_HAZ_OFF} state_t;
   state_t state_q, state_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic bnd;
   logic [N-1:0] therm;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         phase_q <= PW'(1);
         cnt_q   <= CW'(DIV - 1);
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
      end
   end
   always_comb begin
      bnd     = cnt_q == CW'(DIV - 1);
      state_d = state_q;
      phase_d = phase_q;
      cnt_d   = cnt_q + 1'b1;
      case (state_q)
         S_IDLE: begin
            cnt_d = bnd ? cnt_q : cnt_q + 1'b1;
            if (hazard) begin
               state_d = S_HAZ_ON;
               cnt_d   = '0;
            end else if (bnd && (left || right)) begin
               state_d = left ? S_LEFT : S_RIGHT;
               phase_d = PW'(1);
               cnt_d   = '0;
            end
         end
         S_LEFT, S_RIGHT: begin
            if (hazard) begin
               state_d = S_HAZ_ON;
               cnt_d   = '0;
            end else if (bnd) begin
               cnt_d   = '0;
               state_d = (phase_q < PW'(N)) ? state_q : S_IDLE;
               phase_d = (phase_q < PW'(N)) ? phase_q + 1'b1 : phase_q;
            end
         end
         S_HAZ_ON: begin
            if (bnd) begin
               state_d = S_HAZ_OFF;
               cnt_d   = '0;
            end
         end
         S_HAZ_OFF: begin
            // Leaving to IDLE with a full count: the off gap has already been served
            if (bnd) begin
               state_d = hazard ? S_HAZ_ON : S_IDLE;
               cnt_d   = hazard ? '0 : CW'(DIV - 1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = CW'(DIV - 1);
         end
      endcase
   end
   always_comb begin
      therm   = ~({N{1'b1}} << phase_q);
      lamps_l = (state_q == S_LEFT) ? therm : (state_q == S_HAZ_ON) ? '1 : '0;
      lamps_r = (state_q == S_RIGHT) ? therm : (state_q == S_HAZ_ON) ? '1 : '0;
      busy    = state_q != S_IDLE;
   end
endmodule

// File: tb/tb_tail_sequencer.sv
// tb_tail_sequencer: directed checks of tail_sequencer across several N/DIV configurations
module tb_tail_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic left = 1'b0;
   logic right = 1'b0;
   logic hazard = 1'b0;
   logic [2:0] a_l, a_r, c_l, c_r, d_l, d_r;
   logic [3:0] b_l, b_r;
   logic a_busy, b_busy, c_busy, d_busy;
   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   tail_sequencer #(.N(3), .DIV(1)) u_a (.clk(clk), .reset(reset), .left(left), .right(right),
      .hazard(hazard), .lamps_l(a_l), .lamps_r(a_r), .busy(a_busy));
   tail_sequencer #(.N(4), .DIV(2)) u_b (.clk(clk), .reset(reset), .left(left), .right(right),
      .hazard(hazard), .lamps_l(b_l), .lamps_r(b_r), .busy(b_busy));
   tail_sequencer #(.N(3), .DIV(2)) u_c (.clk(clk), .reset(reset), .left(left), .right(right),
      .hazard(hazard), .lamps_l(c_l), .lamps_r(c_r), .busy(c_busy));
   tail_sequencer #(.N(3), .DIV(3)) u_d (.clk(clk), .reset(reset), .left(left), .right(right),
      .hazard(hazard), .lamps_l(d_l), .lamps_r(d_r), .busy(d_busy));

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      left = 1'b0;
      right = 1'b0;
      hazard = 1'b0;
      reset = 1'b1;
      step();
      check("rst_a_l", a_l, 0);
      check("rst_b_r", b_r, 0);
      check("rst_busy", {a_busy, b_busy, c_busy, d_busy}, 0);
      reset = 1'b0;
   endtask

   initial begin
      int exp_l1 [5] = '{1, 3, 7, 0, 1};
      int exp_b1 [5] = '{1, 1, 1, 0, 1};
      int exp_r2 [12] = '{1, 1, 3, 3, 7, 7, 15, 15, 0, 0, 0, 0};
      int exp_h3 [7] = '{7, 7, 0, 0, 7, 7, 0};
      int exp_l3 [3] = '{1, 1, 3};
      // N=3 DIV=1: left held from reset release
      do_reset();
      left = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("t1_l%0d", i), a_l, exp_l1[i]);
         check($sformatf("t1_r%0d", i), a_r, 0);
         check($sformatf("t1_busy%0d", i), a_busy, exp_b1[i]);
      end
      // N=4 DIV=2: single-cycle right pulse
      do_reset();
      right = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         if (i == 0) right = 1'b0;
         check($sformatf("t2_r%0d", i), b_r, exp_r2[i]);
         check($sformatf("t2_l%0d", i), b_l, 0);
         check($sformatf("t2_busy%0d", i), b_busy, (i < 8) ? 1 : 0);
      end
      // N=3 DIV=2: hazard preempts left while 011 is shown
      do_reset();
      left = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("t3_pre%0d", i), c_l, exp_l3[i]);
      end
      hazard = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         check($sformatf("t3_l%0d", i), c_l, exp_h3[i]);
         check($sformatf("t3_r%0d", i), c_r, exp_h3[i]);
         check($sformatf("t3_busy%0d", i), c_busy, 1);
      end
      // N=3 DIV=1: left+right counts as left; with hazard too, hazard wins
      do_reset();
      left = 1'b1;
      right = 1'b1;
      step();
      check("t4_l0", a_l, 1);
      check("t4_r0", a_r, 0);
      step();
      check("t4_l1", a_l, 3);
      check("t4_r1", a_r, 0);
      do_reset();
      left = 1'b1;
      right = 1'b1;
      hazard = 1'b1;
      step();
      check("t4_hl", a_l, 7);
      check("t4_hr", a_r, 7);
      // N=3 DIV=3: hazard pulse gives one full flash, then no extra gap
      do_reset();
      hazard = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         if (i == 0) hazard = 1'b0;
         check($sformatf("t5_l%0d", i), d_l, (i < 3) ? 7 : 0);
         check($sformatf("t5_r%0d", i), d_r, (i < 3) ? 7 : 0);
         check($sformatf("t5_busy%0d", i), d_busy, (i < 6) ? 1 : 0);
      end
      left = 1'b1;
      step();
      check("t5_restart", d_l, 1);
      check("t5_restart_busy", d_busy, 1);
      // N=3 DIV=2: async reset while 111 shown
      do_reset();
      left = 1'b1;
      for (int i = 0; i < 5; i++) step();
      check("t6_full", c_l, 7);
      #2;
      reset = 1'b1;
      #1;
      check("t6_async_l", c_l, 0);
      check("t6_async_busy", c_busy, 0);
      #2;
      reset = 1'b0;
      step();
      check("t6_resume", c_l, 1);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
